// File: rtl/dmem_pkg.sv
// Shared types and helpers for the Rx32 data-memory responder.
//   wb_entry_t : one posted write (word index + data)
//   addr_ok()  : word-aligned and inside the RAM window
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH = 1024;
  localparam int unsigned IDX_W      = $clog2(DMEM_DEPTH);
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 32;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // off is the byte offset from the RAM base; depth is in words.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] off, input int unsigned depth);
    logic [ADDR_W:0] limit;
    limit = (ADDR_W+1)'(depth) << 2;
    return (off[1:0] == 2'b00) && ({1'b0, off} < limit);
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// Posted write buffer: FIFO of wb_entry_t with a CAM lookup on word index.
// Ports:
//   clk, reset                 clock, async active-low reset (clears pointers)
//   push, pushEntry            append an entry at the tail
//   pop, head_c                remove / observe the oldest entry
//   full, empty                registered occupancy flags
//   lookupIdx                  index to search for
//   lookupHit_c, lookupData_c  any valid match, data of the youngest match
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  wb_entry_t         pushEntry,
  input  logic              pop,
  output wb_entry_t         head_c,
  output logic              full,
  output logic              empty,
  input  logic [IDX_W-1:0]  lookupIdx,
  output logic              lookupHit_c,
  output logic [DATA_W-1:0] lookupData_c
);

  localparam int unsigned PTR_W = $clog2(WB_DEPTH);

  wb_entry_t        entries [WB_DEPTH];
  logic [PTR_W:0]   wrPtr, rdPtr, wrPtrNext, rdPtrNext, count;
  logic [PTR_W-1:0] slot;

  // Next pointers; the extra MSB distinguishes full from empty.
  always_comb begin
    wrPtrNext = wrPtr + (PTR_W+1)'(push);
    rdPtrNext = rdPtr + (PTR_W+1)'(pop);
    count     = wrPtr - rdPtr;
  end

  // Pointer and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      wrPtr <= wrPtrNext;
      rdPtr <= rdPtrNext;
      empty <= (wrPtrNext == rdPtrNext);
      full  <= (wrPtrNext[PTR_W] != rdPtrNext[PTR_W]) &&
               (wrPtrNext[PTR_W-1:0] == rdPtrNext[PTR_W-1:0]);
    end
  end

  // Entry storage; validity comes from the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) entries[wrPtr[PTR_W-1:0]] <= pushEntry;
  end

  assign head_c = entries[rdPtr[PTR_W-1:0]];

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    lookupHit_c  = 1'b0;
    lookupData_c = '0;
    slot         = '0;
    for (int unsigned k = 0; k < WB_DEPTH; k++) begin
      slot = rdPtr[PTR_W-1:0] + PTR_W'(k);
      if (((PTR_W+1)'(k) < count) && (entries[slot].idx == lookupIdx)) begin
        lookupHit_c  = 1'b1;
        lookupData_c = entries[slot].data;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Rx32 data-port responder: single-port word RAM behind a posted write buffer,
// with load forwarding from pending stores and a fixed 1-cycle response.
// Ports:
//   clk, reset                 clock, async active-low reset
//   req_valid/we/addr/wdata    M-stage request (byte address, store data)
//   req_ready                  low only while the write buffer is full
//   rsp_valid/rdata/err        response one cycle after each accept
//   wb_empty                   no posted writes pending
// DEPTH must match dmem_pkg::DMEM_DEPTH (entry index width comes from the pkg).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = DMEM_DEPTH,
  parameter int unsigned WB_DEPTH  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        wb_empty
);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  reqIdx;
  logic              addrOk, accept, loadAcc, storeAcc, drain;
  logic              wbFull, wbEmpty, fwdHit;
  logic [DATA_W-1:0] fwdData;
  wb_entry_t         head, pushEntry;

  logic              loadOkQ, fwdSelQ;
  logic [DATA_W-1:0] fwdDataQ, ramRdQ;

  // Decode and RAM-port arbitration: an accepted load owns the port,
  // otherwise the buffer head drains.
  always_comb begin
    off       = req_addr - BASE_ADDR;
    addrOk    = addr_ok(off, DEPTH);
    reqIdx    = off[2 +: IDX_W];
    accept    = req_valid && !wbFull;
    loadAcc   = accept && !req_we;
    storeAcc  = accept && req_we && addrOk;
    drain     = !loadAcc && !wbEmpty;
    pushEntry = '{idx: reqIdx, data: req_wdata};
  end

  assign req_ready = !wbFull;
  assign wb_empty  = wbEmpty;

  dmem_wbuf #(.WB_DEPTH(WB_DEPTH)) u_wbuf (
    .clk          (clk),
    .reset        (reset),
    .push         (storeAcc),
    .pushEntry    (pushEntry),
    .pop          (drain),
    .head_c       (head),
    .full         (wbFull),
    .empty        (wbEmpty),
    .lookupIdx    (reqIdx),
    .lookupHit_c  (fwdHit),
    .lookupData_c (fwdData)
  );

  // Single-port RAM: write and read are mutually exclusive by arbitration.
  always_ff @(posedge clk) begin
    if (drain)   mem[head.idx] <= head.data;
    if (loadAcc) ramRdQ <= mem[reqIdx];
  end

  // Response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      loadOkQ   <= 1'b0;
      fwdSelQ   <= 1'b0;
      fwdDataQ  <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept && !addrOk;
      loadOkQ   <= loadAcc && addrOk;
      fwdSelQ   <= fwdHit;
      fwdDataQ  <= fwdData;
    end
  end

  // Forwarded data overrides the RAM read; stores and errors return 0.
  assign rsp_rdata = !loadOkQ ? '0 : (fwdSelQ ? fwdDataQ : ramRdQ);

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH    = 1024;
  localparam int unsigned WB_DEPTH = 4;
  localparam logic [31:0] BASE     = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, wb_empty;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WB_DEPTH(WB_DEPTH), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wb_empty  (wb_empty)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: memory image plus an ordered list of pending stores.
  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } pend_t;

  logic [31:0] refMem [DEPTH];
  bit          refInit [DEPTH];
  pend_t       pendQ [$];
  logic        expValid = 1'b0;
  logic        expErr = 1'b0;
  logic [31:0] expData = '0;
  bit          expDataKnown = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    assert (got === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkOutputs();
    chk("rsp_valid", 32'(rsp_valid), 32'(expValid));
    if (expValid) begin
      chk("rsp_err", 32'(rsp_err), 32'(expErr));
      if (expDataKnown) chk("rsp_rdata", rsp_rdata, expData);
    end
    chk("req_ready", 32'(req_ready), 32'(pendQ.size() < WB_DEPTH));
    chk("wb_empty", 32'(wb_empty), 32'(pendQ.size() == 0));
  endtask

  // Apply one request's effect per the behavioural rules.
  task automatic modelCycle(input logic v, input logic we, input logic [31:0] a,
                            input logic [31:0] d);
    bit          ready = (pendQ.size() < WB_DEPTH);
    bit          acc = v && ready;
    logic [31:0] offs = a - BASE;
    bit          ok = (offs % 4 == 0) && (offs < DEPTH * 4);
    int unsigned idx = (offs / 4) % DEPTH;
    bit          found = 1'b0;
    pend_t       p;
    expValid     = acc;
    expErr       = acc && !ok;
    expData      = '0;
    expDataKnown = 1'b1;
    if (acc && !we && ok) begin
      for (int i = pendQ.size() - 1; i >= 0 && !found; i--) begin
        if (pendQ[i].idx == idx) begin
          expData = pendQ[i].data;
          found   = 1'b1;
        end
      end
      if (!found) begin
        if (refInit[idx]) expData = refMem[idx];
        else expDataKnown = 1'b0;
      end
    end
    if (!(acc && !we) && pendQ.size() > 0) begin
      p = pendQ.pop_front();
      refMem[p.idx]  = p.data;
      refInit[p.idx] = 1'b1;
    end
    if (acc && we && ok) pendQ.push_back('{idx: idx, data: d});
  endtask

  task automatic step(input logic v, input logic we, input logic [31:0] a,
                      input logic [31:0] d);
    @(negedge clk);
    checkOutputs();
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    modelCycle(v, we, a, d);
  endtask

  function automatic logic [31:0] poolAddr(input int unsigned k);
    return (k < 16) ? 32'(k * 4) : 32'((1000 + k) * 4);
  endfunction

  initial begin
    logic [31:0] a;
    int unsigned k;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    chk("reset_wb_empty", 32'(wb_empty), 32'h1);
    reset = 1'b1;

    // Seed every address the random phase will touch
    for (int unsigned i = 0; i < 24; i++) step(1'b1, 1'b1, poolAddr(i), $urandom);

    // Store then immediate load: forwarded from the buffer
    step(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    step(1'b1, 1'b0, 32'h10, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);

    // Two stores to one address; youngest wins before and after drain
    step(1'b1, 1'b1, 32'h20, 32'h1);
    step(1'b1, 1'b1, 32'h20, 32'h2);
    step(1'b1, 1'b0, 32'h20, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h20, 32'h0);

    // Misaligned load, out-of-range store, last word, word 0 unchanged
    step(1'b1, 1'b0, 32'h13, 32'h0);
    step(1'b1, 1'b1, 32'h1000, 32'hBAD0BAD0);
    step(1'b1, 1'b1, 32'h0FFC, 32'hCAFE0FFC);
    step(1'b1, 1'b0, 32'h0FFC, 32'h0);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);

    // Loads hold off draining; drain on the first idle cycle
    step(1'b1, 1'b1, 32'h24, 32'h11112222);
    step(1'b1, 1'b0, 32'h8, 32'h0);
    step(1'b1, 1'b0, 32'h24, 32'h0);
    step(1'b1, 1'b0, 32'hC, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h24, 32'h0);

    // Reset while a store is still pending: it must never reach RAM
    step(1'b1, 1'b1, 32'h30, 32'h5A5A5A5A);
    @(negedge clk);
    checkOutputs();
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midreset_wb_empty", 32'(wb_empty), 32'h1);
    chk("midreset_req_ready", 32'(req_ready), 32'h1);
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'h0);
    pendQ.delete();
    expValid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, 32'h30, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);

    // Randomized traffic over the seeded window plus error addresses
    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, 29);
      if (k < 24)       a = poolAddr(k);
      else if (k < 27)  a = poolAddr($urandom_range(0, 23)) + 32'(k - 23);
      else if (k == 27) a = 32'h1000;
      else if (k == 28) a = 32'hFFFFFFFC;
      else              a = 32'h1004;
      step($urandom_range(0, 9) < 8, $urandom_range(0, 2) == 0, a, $urandom);
    end

    repeat (4) step(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
